fw_operand_bypass: RTL and testbench
====================================

// Module: fw_operand_bypass
// PURPOSE
//  EX-stage consumer of the registered forwarding-control bus. Resolves rs1/rs2 operands from the
//  register file or from the MEM, WB and WB-late result sources.
//  Owns the load-use interlock: the forwarding controller never forwards from a load in EX, so this
//  block stalls and bubbles instead.
//  Holds resolved operands across EX freezes and counts load-use stall cycles.
// PARAMETERS
//  XLEN     32  operand/result width
//  CNT_W    16  width of load-use stall counter
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, asynchronous, active-low
//  rs1_sel_i      in   2      rs1 source: 0 NONE(rf) 1 MEM 2 WB 3 WBLATE (registered fw select, EX-aligned)
//  rs2_sel_i      in   2      rs2 source, same encoding
//  rs1_rf_i       in   XLEN   register-file rs1 value of instr in EX
//  rs2_rf_i       in   XLEN   register-file rs2 value of instr in EX
//  mem_result_i   in   XLEN   ALU result of instr in MEM
//  wb_result_i    in   XLEN   final result of instr in WB
//  wb_wr_en_i     in   1      instr in WB writes rf
//  hold_i         in   1      EX freeze (downstream busy); MEM/WB keep advancing
//  id_valid_i     in   1      ID holds a valid instr
//  id_rs1_i       in   5      ID rs1 index
//  id_rs2_i       in   5      ID rs2 index
//  ex_is_load_i   in   1      instr in EX is a load
//  ex_rd_i        in   5      EX destination index
//  dmem_ready_i   in   1      data memory returns load data this cycle
//  rs1_val_o      out  XLEN   resolved rs1 operand
//  rs2_val_o      out  XLEN   resolved rs2 operand
//  load_stall_o   out  1      freeze IF/ID (Mealy)
//  bubble_o       out  1      inject NOP into EX next edge
//  lu_stall_cnt_o out  CNT_W  saturating count of load_stall_o cycles
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM=IDLE; late_q, hold_q, hold regs and counter all cleared.
//   - load_stall_o=0, bubble_o=0, lu_stall_cnt_o=0.
//   - rs*_val_o follow the comb mux; the rs*_sel inputs are 0 out of reset, so rs*_val_o=rs*_rf_i.
//  late_q:
//   - Loads wb_result_i on each posedge where wb_wr_en_i=1.
//   - Is the WBLATE source, i.e. the value one cycle after WB.
//  Operand mux (comb, 0 latency):
//   - sel 0 -> rf, 1 -> mem_result_i, 2 -> wb_result_i, 3 -> late_q.
//   - rs1 and rs2 resolve independently.
//  Hold:
//   - hold_q <= hold_i.
//   - On a posedge with hold_i=1 and hold_q=0, latch both resolved operands into hold1_q/hold2_q.
//   - While hold_q=1 (including the release cycle, where hold_i=0), rs*_val_o = hold regs.
//   - Back-to-back holds do not re-latch.
//  Load-use hazard:
//   - lu = id_valid_i & ex_is_load_i & ex_rd_i!=0 & (id_rs1_i==ex_rd_i | id_rs2_i==ex_rd_i).
//  FSM {IDLE, MEM_WAIT}:
//   - IDLE, lu=1: load_stall_o=1, bubble_o=1; next = dmem_ready_i ? IDLE : MEM_WAIT.
//   - IDLE, lu=0: outputs 0; stay IDLE.
//   - MEM_WAIT: load_stall_o=1, bubble_o=1; go to IDLE on the cycle dmem_ready_i=1 (outputs still 1 that cycle).
//   - hold_i=1 in IDLE suppresses lu evaluation (EX frozen, no stall); MEM_WAIT ignores hold_i.
//  Counter:
//   - +1 per cycle with load_stall_o=1; saturates at all-ones, no wrap.
//  Reset mid-MEM_WAIT: immediate return to IDLE, outputs 0.
// TESTING
//  T1: rs1_sel=1 mem=0x11, rs2_sel=3, late_q loaded 0x33 the prior cycle
//      -> rs1_val=0x11, rs2_val=0x33 in the same cycle.
//  T2: ex load rd=5, id rs2=5, dmem_ready=1
//      -> 1 cycle load_stall_o=bubble_o=1, FSM stays IDLE, cnt=1.
//  T3: same hazard, dmem_ready low 3 cycles then high
//      -> stall/bubble for 4 cycles, then IDLE, cnt=4.
//  T4: rs1_sel=2 wb=0xAA, hold_i high 3 cycles while wb changes to 0xBB
//      -> rs1_val=0xAA through the release cycle.
//  T5: hazard with ex_rd=0 -> no stall. Preload cnt near all-ones, stall 3 cycles -> cnt stays all-ones.
//  T6: rst low during MEM_WAIT -> outputs 0 asynchronously; after release, IDLE with cnt=0.

Source files
------------

// File: rtl/fw_operand_bypass_if.sv
// Handshake/data bundle between the EX-stage operand bypass and its
// surroundings: forwarding selects, result sources, hazard inputs, outputs.
interface fw_operand_bypass_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [1:0]       rs1_sel_i;
    logic [1:0]       rs2_sel_i;
    logic [XLEN-1:0]  rs1_rf_i;
    logic [XLEN-1:0]  rs2_rf_i;
    logic [XLEN-1:0]  mem_result_i;
    logic [XLEN-1:0]  wb_result_i;
    logic             wb_wr_en_i;
    logic             hold_i;
    logic             id_valid_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             ex_is_load_i;
    logic [4:0]       ex_rd_i;
    logic             dmem_ready_i;
    logic [XLEN-1:0]  rs1_val_o;
    logic [XLEN-1:0]  rs2_val_o;
    logic             load_stall_o;
    logic             bubble_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;

    modport master (
        output rs1_sel_i, rs2_sel_i,
        output rs1_rf_i, rs2_rf_i,
        output mem_result_i, wb_result_i, wb_wr_en_i,
        output hold_i,
        output id_valid_i, id_rs1_i, id_rs2_i,
        output ex_is_load_i, ex_rd_i, dmem_ready_i,
        input  rs1_val_o, rs2_val_o,
        input  load_stall_o, bubble_o, lu_stall_cnt_o
    );

    modport slave (
        input  rs1_sel_i, rs2_sel_i,
        input  rs1_rf_i, rs2_rf_i,
        input  mem_result_i, wb_result_i, wb_wr_en_i,
        input  hold_i,
        input  id_valid_i, id_rs1_i, id_rs2_i,
        input  ex_is_load_i, ex_rd_i, dmem_ready_i,
        output rs1_val_o, rs2_val_o,
        output load_stall_o, bubble_o, lu_stall_cnt_o
    );
endinterface

// File: rtl/fw_operand_bypass.sv
// EX-stage operand bypass: resolves rs1/rs2 from rf/MEM/WB/WB-late,
// holds operands across EX freezes and owns the load-use interlock.
module fw_operand_bypass #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    fw_operand_bypass_if.slave bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  late_q, late_d;
    logic             hold_q, hold_d;
    logic [XLEN-1:0]  hold1_q, hold1_d;
    logic [XLEN-1:0]  hold2_q, hold2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  mux1, mux2;
    logic             lu;
    logic             stall_raw;
    logic             stall;

    function automatic logic [XLEN-1:0] pick(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] wb,
        input logic [XLEN-1:0] late
    );
        logic [XLEN-1:0] v;
        v = rf;
        unique case (sel)
            2'd1:    v = mem;
            2'd2:    v = wb;
            2'd3:    v = late;
            default: v = rf;
        endcase
        return v;
    endfunction

    always_comb begin
        mux1 = pick(bus.rs1_sel_i, bus.rs1_rf_i, bus.mem_result_i,
                    bus.wb_result_i, late_q);
        mux2 = pick(bus.rs2_sel_i, bus.rs2_rf_i, bus.mem_result_i,
                    bus.wb_result_i, late_q);
    end

    assign bus.rs1_val_o = hold_q ? hold1_q : mux1;
    assign bus.rs2_val_o = hold_q ? hold2_q : mux2;

    always_comb begin
        lu = bus.id_valid_i & bus.ex_is_load_i
           & (bus.ex_rd_i != 5'd0)
           & ((bus.id_rs1_i == bus.ex_rd_i)
            | (bus.id_rs2_i == bus.ex_rd_i));
    end

    // A frozen EX cannot advance its load, so IDLE ignores the hazard.
    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.hold_i && lu) begin
                    stall_raw = 1'b1;
                    if (!bus.dmem_ready_i)
                        state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stall_raw = 1'b1;
                if (bus.dmem_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mealy outputs are forced low while reset is asserted.
    assign stall            = stall_raw & rst;
    assign bus.load_stall_o = stall;
    assign bus.bubble_o     = stall;
    assign bus.lu_stall_cnt_o = cnt_q;

    always_comb begin
        late_d = late_q;
        if (bus.wb_wr_en_i)
            late_d = bus.wb_result_i;
    end

    always_comb begin
        hold_d  = bus.hold_i;
        hold1_d = hold1_q;
        hold2_d = hold2_q;
        if (bus.hold_i && !hold_q) begin
            hold1_d = mux1;
            hold2_d = mux2;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            late_q  <= '0;
            hold_q  <= 1'b0;
            hold1_q <= '0;
            hold2_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            late_q  <= late_d;
            hold_q  <= hold_d;
            hold1_q <= hold1_d;
            hold2_q <= hold2_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fw_operand_bypass.sv
// Self-checking bench: operand mux table, hand-written hazard/hold/reset
// sequences and randomized traffic against a behavioural model.
module tb_fw_operand_bypass;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fw_operand_bypass_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    fw_operand_bypass #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [XLEN-1:0] m_late, m_h1, m_h2;
    bit              m_hold, m_wait;
    int              m_cnt;

    typedef struct {
        logic [1:0]      s1, s2;
        logic [XLEN-1:0] rf1, rf2, mem, wb;
        logic [XLEN-1:0] e1, e2;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] src(input logic [1:0] s,
                                            input logic [XLEN-1:0] rf);
        case (s)
            2'd0:    return rf;
            2'd1:    return bus.mem_result_i;
            2'd2:    return bus.wb_result_i;
            default: return m_late;
        endcase
    endfunction

    task automatic model_reset();
        m_late = '0; m_h1 = '0; m_h2 = '0;
        m_hold = 0; m_wait = 0; m_cnt = 0;
    endtask

    task automatic quiet();
        bus.rs1_sel_i = 2'd0; bus.rs2_sel_i = 2'd0;
        bus.rs1_rf_i = 32'h0000_0101; bus.rs2_rf_i = 32'h0000_0202;
        bus.mem_result_i = '0; bus.wb_result_i = '0;
        bus.wb_wr_en_i = 1'b0; bus.hold_i = 1'b0;
        bus.id_valid_i = 1'b0; bus.id_rs1_i = '0; bus.id_rs2_i = '0;
        bus.ex_is_load_i = 1'b0; bus.ex_rd_i = '0;
        bus.dmem_ready_i = 1'b1;
    endtask

    task automatic hazard(input logic [4:0] rd, input logic rdy);
        bus.id_valid_i = 1'b1; bus.ex_is_load_i = 1'b1;
        bus.ex_rd_i = rd; bus.id_rs1_i = 5'd30; bus.id_rs2_i = rd;
        bus.dmem_ready_i = rdy;
    endtask

    // Called at a negedge with inputs already applied.
    task automatic step();
        logic [XLEN-1:0] m1, m2;
        bit lu, st;
        #1;
        m1 = src(bus.rs1_sel_i, bus.rs1_rf_i);
        m2 = src(bus.rs2_sel_i, bus.rs2_rf_i);
        lu = bus.id_valid_i && bus.ex_is_load_i && (bus.ex_rd_i != 0) &&
             (bus.id_rs1_i == bus.ex_rd_i || bus.id_rs2_i == bus.ex_rd_i);
        st = m_wait || (!bus.hold_i && lu);
        chk("rs1_val", 64'(bus.rs1_val_o), 64'(m_hold ? m_h1 : m1));
        chk("rs2_val", 64'(bus.rs2_val_o), 64'(m_hold ? m_h2 : m2));
        chk("load_stall", 64'(bus.load_stall_o), 64'(st));
        chk("bubble", 64'(bus.bubble_o), 64'(st));
        chk("lu_cnt", 64'(bus.lu_stall_cnt_o), 64'(m_cnt));
        @(posedge clk);
        if (bus.wb_wr_en_i) m_late = bus.wb_result_i;
        if (bus.hold_i && !m_hold) begin m_h1 = m1; m_h2 = m2; end
        m_hold = bus.hold_i;
        if (st && m_cnt < CMAX) m_cnt++;
        m_wait = st && !bus.dmem_ready_i;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        quiet();
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_stall", 64'(bus.load_stall_o), 64'd0);
        chk("rst_cnt", 64'(bus.lu_stall_cnt_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{2'd1, 2'd3, 32'hA1, 32'hA2, 32'h11, 32'h22, 32'h11, 32'h33};
        tbl[1] = '{2'd0, 2'd0, 32'hA1, 32'hA2, 32'h11, 32'h22, 32'hA1, 32'hA2};
        tbl[2] = '{2'd2, 2'd1, 32'hA1, 32'hA2, 32'h44, 32'h55, 32'h55, 32'h44};
        tbl[3] = '{2'd3, 2'd2, 32'hB1, 32'hB2, 32'h66, 32'h77, 32'h33, 32'h77};
        tbl[4] = '{2'd0, 2'd3, 32'hC1, 32'hC2, 32'h88, 32'h99, 32'hC1, 32'h33};
        tbl[5] = '{2'd2, 2'd2, 32'hD1, 32'hD2, 32'hEE, 32'hFFFF_0000,
                   32'hFFFF_0000, 32'hFFFF_0000};

        quiet();
        model_reset();
        #2;
        chk("reset_rs1", 64'(bus.rs1_val_o), 64'h101);
        chk("reset_rs2", 64'(bus.rs2_val_o), 64'h202);
        chk("reset_stall", 64'(bus.load_stall_o), 64'd0);
        chk("reset_bubble", 64'(bus.bubble_o), 64'd0);
        chk("reset_cnt", 64'(bus.lu_stall_cnt_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // T1 and mux table: late_q preloaded with 0x33
        bus.wb_wr_en_i = 1'b1; bus.wb_result_i = 32'h33;
        step();
        bus.wb_wr_en_i = 1'b0;
        foreach (tbl[i]) begin
            bus.rs1_sel_i = tbl[i].s1; bus.rs2_sel_i = tbl[i].s2;
            bus.rs1_rf_i = tbl[i].rf1; bus.rs2_rf_i = tbl[i].rf2;
            bus.mem_result_i = tbl[i].mem; bus.wb_result_i = tbl[i].wb;
            #1;
            chk("tbl_rs1", 64'(bus.rs1_val_o), 64'(tbl[i].e1));
            chk("tbl_rs2", 64'(bus.rs2_val_o), 64'(tbl[i].e2));
            step();
        end

        // T2: single-cycle stall with data ready
        do_reset();
        hazard(5'd5, 1'b1);
        #1;
        chk("t2_stall", 64'(bus.load_stall_o), 64'd1);
        chk("t2_bubble", 64'(bus.bubble_o), 64'd1);
        step();
        quiet();
        #1;
        chk("t2_idle", 64'(bus.load_stall_o), 64'd0);
        chk("t2_cnt", 64'(bus.lu_stall_cnt_o), 64'd1);
        step();

        // T3: three wait cycles then ready
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hazard(5'd5, i == 3);
            #1;
            chk("t3_stall", 64'(bus.load_stall_o), 64'd1);
            step();
        end
        quiet();
        #1;
        chk("t3_idle", 64'(bus.load_stall_o), 64'd0);
        chk("t3_cnt", 64'(bus.lu_stall_cnt_o), 64'd4);
        step();

        // T4: operand held across freeze while WB changes
        do_reset();
        bus.rs1_sel_i = 2'd2; bus.wb_result_i = 32'hAA; bus.hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) bus.wb_result_i = 32'hBB;
            bus.hold_i = (i < 3);
            #1;
            chk("t4_hold", 64'(bus.rs1_val_o), 64'hAA);
            step();
        end
        #1;
        chk("t4_after", 64'(bus.rs1_val_o), 64'hBB);
        step();

        // T5: rd=0 never stalls; hold masks hazard; counter saturates
        do_reset();
        hazard(5'd0, 1'b1);
        bus.id_rs1_i = 5'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_rd0", 64'(bus.load_stall_o), 64'd0);
            step();
        end
        hazard(5'd7, 1'b1);
        bus.hold_i = 1'b1;
        #1;
        chk("t5_holdmask", 64'(bus.load_stall_o), 64'd0);
        step();
        bus.hold_i = 1'b0;
        for (int i = 0; i < CMAX - 2; i++) step();
        #1;
        chk("t5_near", 64'(bus.lu_stall_cnt_o), 64'(CMAX - 2));
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("t5_sat", 64'(bus.lu_stall_cnt_o), 64'(CMAX));
        step();

        // T6: async reset while waiting on memory
        do_reset();
        hazard(5'd9, 1'b0);
        step();
        #1;
        chk("t6_wait", 64'(bus.load_stall_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_stall", 64'(bus.load_stall_o), 64'd0);
        chk("t6_rst_bubble", 64'(bus.bubble_o), 64'd0);
        chk("t6_rst_cnt", 64'(bus.lu_stall_cnt_o), 64'd0);
        model_reset();
        @(negedge clk);
        quiet();
        rst = 1'b1;
        #1;
        chk("t6_idle", 64'(bus.load_stall_o), 64'd0);
        step();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.rs1_sel_i = 2'($urandom_range(0, 3));
            bus.rs2_sel_i = 2'($urandom_range(0, 3));
            bus.rs1_rf_i = $urandom; bus.rs2_rf_i = $urandom;
            bus.mem_result_i = $urandom; bus.wb_result_i = $urandom;
            bus.wb_wr_en_i = 1'($urandom_range(0, 1));
            bus.hold_i = ($urandom_range(0, 3) == 0);
            bus.id_valid_i = 1'($urandom_range(0, 1));
            bus.id_rs1_i = 5'($urandom_range(0, 3));
            bus.id_rs2_i = 5'($urandom_range(0, 3));
            bus.ex_is_load_i = 1'($urandom_range(0, 1));
            bus.ex_rd_i = 5'($urandom_range(0, 3));
            bus.dmem_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
